// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//
// Synchronous FIFO controller for an external simple dual-port RAM with a
// 1-cycle registered read, no read enable and undefined same-address
// read/write behaviour. Owns the write/read pointers, RAM occupancy, one
// outstanding-read flag and a 2-entry register output buffer, so a word can
// be both pushed and popped every cycle.
//
// Optional feature macro: FIFO_CTRL_ERROR_EN
//   When defined, adds sticky err_overflow / err_underflow flags and an
//   err_clear input. When undefined, those ports and their logic are absent.
//
// Ports
//   clk, rst          single clock; asynchronous active-high reset
//   push_valid/ready  producer handshake, push_data is the word to enqueue
//   pop_valid/ready   consumer handshake, pop_data is the head word
//   level             words held: RAM + output buffer + read in flight
//   ram_waddr/wdata/we  RAM write port
//   ram_raddr/rdata     RAM read port (rdata valid one cycle after raddr)
//   err_*             (FIFO_CTRL_ERROR_EN only) sticky error flags
module ram_fifo_ctrl #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 16,
  localparam int ADDR_BITS = $clog2(DEPTH),
  localparam int LVL_W     = $clog2(DEPTH + 3)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid,
  output logic                 push_ready,
  input  logic [WIDTH-1:0]     push_data,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic [WIDTH-1:0]     pop_data,
`ifdef FIFO_CTRL_ERROR_EN
  input  logic                 err_clear,
  output logic                 err_overflow,
  output logic                 err_underflow,
`endif
  output logic [LVL_W-1:0]     level,
  output logic [ADDR_BITS-1:0] ram_waddr,
  output logic [WIDTH-1:0]     ram_wdata,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_raddr,
  input  logic [WIDTH-1:0]     ram_rdata
);

  localparam logic [ADDR_BITS:0] FULL_WORDS = (ADDR_BITS + 1)'(DEPTH);

  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_ram_words;
  logic                 r_rd_pending;
  logic [1:0]           r_out_count;
  logic [WIDTH-1:0]     r_buf0;   // head entry
  logic [WIDTH-1:0]     r_buf1;

  logic       w_push_ready;
  logic       w_push_fire;
  logic       w_pop_fire;
  logic       w_rd_issue;
  logic [2:0] w_out_demand;
  logic [1:0] w_cap_idx;

  // push_ready comes only from registered occupancy, forced low during reset
  assign w_push_ready = ~rst & (r_ram_words != FULL_WORDS);
  assign w_push_fire  = push_valid & w_push_ready;
  assign w_pop_fire   = (r_out_count != 2'd0) & pop_ready;

  // Words that will sit in (or be headed for) the output buffer after this
  // cycle's pop; a new read may only be issued if that leaves a free slot.
  assign w_out_demand = {1'b0, r_out_count} + {2'b00, r_rd_pending}
                        - {2'b00, w_pop_fire};
  assign w_rd_issue   = (r_ram_words != '0) & (w_out_demand < 3'd2);

  // Returning read data lands behind whatever survives this cycle's pop
  assign w_cap_idx = r_out_count - {1'b0, w_pop_fire};

  assign push_ready = w_push_ready;
  assign ram_we     = w_push_fire;
  assign ram_waddr  = r_wr_ptr;
  assign ram_wdata  = push_data;
  assign ram_raddr  = r_rd_ptr;
  assign pop_valid  = (r_out_count != 2'd0);
  assign pop_data   = r_buf0;
  assign level      = LVL_W'(r_ram_words) + LVL_W'(r_out_count)
                      + LVL_W'(r_rd_pending);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ram_words  <= '0;
      r_rd_pending <= 1'b0;
      r_out_count  <= 2'd0;
      r_buf0       <= '0;
      r_buf1       <= '0;
    end else begin
      if (w_push_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_issue)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ram_words  <= r_ram_words + (ADDR_BITS + 1)'(w_push_fire)
                      - (ADDR_BITS + 1)'(w_rd_issue);
      r_rd_pending <= w_rd_issue;
      r_out_count  <= r_out_count + 2'(r_rd_pending) - 2'(w_pop_fire);

      // Shift on pop first; a capture into slot 0 in the same cycle
      // overrides the shifted value because it is assigned later.
      if (w_pop_fire) r_buf0 <= r_buf1;
      if (r_rd_pending) begin
        if (w_cap_idx == 2'd0) r_buf0 <= ram_rdata;
        else                   r_buf1 <= ram_rdata;
      end
    end
  end

`ifdef FIFO_CTRL_ERROR_EN
  logic r_err_overflow;
  logic r_err_underflow;

  assign err_overflow  = r_err_overflow;
  assign err_underflow = r_err_underflow;

  // Set has priority over clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (push_valid & ~w_push_ready) r_err_overflow <= 1'b1;
      else if (err_clear)             r_err_overflow <= 1'b0;
      if (pop_ready & ~pop_valid)     r_err_underflow <= 1'b1;
      else if (err_clear)             r_err_underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_valid;
  logic             push_ready;
  logic [WIDTH-1:0] push_data;
  logic             pop_valid;
  logic             pop_ready;
  logic [WIDTH-1:0] pop_data;
  logic [LW-1:0]    level;
  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_we;
  logic [AW-1:0]    ram_raddr;
  logic [WIDTH-1:0] ram_rdata;
`ifdef FIFO_CTRL_ERROR_EN
  logic             err_clear;
  logic             err_overflow;
  logic             err_underflow;
`endif

  ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
`ifdef FIFO_CTRL_ERROR_EN
    .err_clear    (err_clear),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow),
`endif
    .level      (level),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: registered read; a same-address read/write returns poisoned
  // data so any capture of it breaks the in-order data check.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_we && ram_waddr == ram_raddr) ram_rdata <= ~ram_wdata;
    else                                  ram_rdata <= mem[ram_raddr];
  end

  typedef struct {
    logic       push_valid;
    logic [7:0] push_data;
    logic       pop_ready;
    logic       exp_push_ready;
    logic       exp_ram_we;
    logic       exp_pop_valid;
    logic [7:0] exp_pop_data;
    logic [4:0] exp_level;
  } vec_t;

  vec_t vecs [13];
  int   checks   = 0;
  int   failures = 0;
  int   hz       = 0;
  logic [7:0] sb [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    if (rst) sb.delete();
    else begin
      if (pop_valid && pop_ready) begin
        chk("sb_nonempty_on_pop", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pop_order", int'(pop_data), int'(e));
        end
      end
      if (push_valid && push_ready) sb.push_back(push_data);
      if (ram_we && !(push_valid && push_ready)) hz++;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  int n, viol_we, viol_rdy, n_push, n_pop, bubbles, stalls;
  logic started;

  initial begin
    //             pv  data  pr  rdy we pval pdata lvl
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0};
    vecs[1]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 5'd1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd2};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd2};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd2};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 5'd1};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0};
    vecs[7]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0};
    vecs[8]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd2};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 5'd2};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 5'd1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0};

    rst = 1'b1; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
`ifdef FIFO_CTRL_ERROR_EN
    err_clear = 1'b0;
`endif

    // Reset state, with a push offered that must be refused
    repeat (2) @(posedge clk);
    #1; push_valid = 1'b1; push_data = 8'h5A;
    sample();
    chk("rst_pop_valid",  pop_valid,  0);
    chk("rst_level",      level,      0);
    chk("rst_ram_we",     ram_we,     0);
    chk("rst_push_ready", push_ready, 0);
    chk("rst_pop_data",   pop_data,   0);
    push_valid = 1'b0;
    adv();
    rst = 1'b0;

    // Directed vector table: latency, simultaneous push/pop, ignored pop
    for (int i = 0; i < 13; i++) begin
      push_valid = vecs[i].push_valid;
      push_data  = vecs[i].push_data;
      pop_ready  = vecs[i].pop_ready;
      sample();
      chk($sformatf("v%0d_push_ready", i), push_ready, vecs[i].exp_push_ready);
      chk($sformatf("v%0d_ram_we", i),     ram_we,     vecs[i].exp_ram_we);
      chk($sformatf("v%0d_pop_valid", i),  pop_valid,  vecs[i].exp_pop_valid);
      chk($sformatf("v%0d_level", i),      level,      vecs[i].exp_level);
      if (vecs[i].exp_pop_valid)
        chk($sformatf("v%0d_pop_data", i), pop_data, vecs[i].exp_pop_data);
      adv();
    end

    // Asynchronous reset mid-operation
    push_valid = 1'b1; pop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_data = 8'(i + 8'h40);
      sample();
      adv();
    end
    push_valid = 1'b0;
    repeat (4) begin sample(); adv(); end
    sample();
    chk("pre_rst_pop_valid", pop_valid, 1);
    adv();
    push_valid = 1'b1; push_data = 8'h99;
    #2; rst = 1'b1; #1;
    chk("midrst_pop_valid",  pop_valid,  0);
    chk("midrst_level",      level,      0);
    chk("midrst_ram_we",     ram_we,     0);
    chk("midrst_push_ready", push_ready, 0);
    chk("midrst_pop_data",   pop_data,   0);
    sample(); adv();
    push_valid = 1'b0;
    sample(); adv();
    rst = 1'b0;
    push_valid = 1'b1; push_data = 8'h77;
    sample();
    chk("postrst_push_ready", push_ready, 1);
    chk("postrst_ram_we",     ram_we,     1);
    chk("postrst_waddr",      ram_waddr,  0);
    adv();
    push_valid = 1'b0; pop_ready = 1'b1;
    repeat (6) begin sample(); adv(); end
    sample();
    chk("postrst_drained_level", level, 0);
    adv();

    // Fill with the consumer stalled: DEPTH+2 words fit
    pop_ready = 1'b0; push_valid = 1'b1;
    n = 0; viol_we = 0; viol_rdy = 0;
    for (int i = 0; i < 25; i++) begin
      push_data = 8'(n);
      sample();
      if (ram_we && !push_ready) viol_we++;
      if (push_ready != (level != 5'd18)) viol_rdy++;
      if (push_ready) n++;
      adv();
    end
    push_valid = 1'b0;
    sample();
    chk("fill_accepted",   n,          18);
    chk("fill_level",      level,      18);
    chk("fill_push_ready", push_ready, 0);
    chk("fill_we_while_full", viol_we, 0);
    chk("fill_ready_vs_level", viol_rdy, 0);
`ifdef FIFO_CTRL_ERROR_EN
    chk("err_overflow_set", err_overflow, 1);
    adv();
    err_clear = 1'b1;
    sample();
    adv();
    err_clear = 1'b0;
    sample();
    chk("err_overflow_cleared", err_overflow, 0);
`endif
    adv();

    // Drain the full FIFO; scoreboard checks order 0..17
    pop_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (level == 0) break;
      adv();
    end
    chk("fill_drain_level", level, 0);
    chk("fill_drain_sb", sb.size(), 0);
    adv();
`ifdef FIFO_CTRL_ERROR_EN
    sample();
    chk("err_underflow_set", err_underflow, 1);
    adv();
`endif

    // Streaming: 64 words, consumer starts 2 cycles late
    n_push = 0; n_pop = 0; bubbles = 0; stalls = 0; started = 1'b0;
    for (int c = 0; c < 120 && n_pop < 64; c++) begin
      push_valid = (n_push < 64);
      push_data  = 8'(n_push + 100);
      pop_ready  = (c >= 2);
      sample();
      if (push_valid && !push_ready) stalls++;
      if (push_valid && push_ready) n_push++;
      if (pop_valid) started = 1'b1;
      if (started && !pop_valid) bubbles++;
      if (pop_valid && pop_ready) n_pop++;
      adv();
    end
    push_valid = 1'b0;
    chk("stream_pops",    n_pop,   64);
    chk("stream_bubbles", bubbles, 0);
    chk("stream_stalls",  stalls,  0);

    // Random backpressure with continuous push
    for (int c = 0; c < 300; c++) begin
      push_valid = 1'b1;
      push_data  = 8'(c);
      pop_ready  = 1'($urandom_range(0, 1));
      sample();
      adv();
    end
    push_valid = 1'b0; pop_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (level == 0) break;
      adv();
    end
    chk("bp_drain_level", level, 0);
    chk("bp_drain_sb", sb.size(), 0);
    chk("ram_we_without_push", hz, 0);
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sequences an external simple dual-port RAM. The RAM has 1-cycle registered read latency, no read enable, and undefined behaviour on a same-address read/write.
- Owns the write/read pointers, the occupancy accounting and a 2-entry output buffer. Presents valid/ready push and pop interfaces with full throughput (1 word/cycle sustained).
- Sits between the RAM instance and any streaming producer/consumer in the SoC, e.g. peripheral TX/RX buffering.

Parameters:
- WIDTH, 8, data word width; must match the RAM word size.
- DEPTH, 16, number of RAM entries; power of 2, ≥2.
- ADDR_BITS, $clog2(DEPTH), RAM address width; derived, not overridden.

Ports:
- clk  input  1  single clock for all logic; the RAM's write and read clocks are tied to it.
- rst  input  1  reset, asynchronous, active-high.
- push_valid  input  1  producer has a word.
- push_ready  output  1  controller accepts the word this cycle.
- push_data  input  WIDTH  word to enqueue.
- pop_valid  output  1  head word available.
- pop_ready  input  1  consumer takes the head word.
- pop_data  output  WIDTH  head word.
- level  output  $clog2(DEPTH+3)  total words held (RAM + output buffer + read in flight).
- ram_waddr  output  ADDR_BITS  RAM write address.
- ram_wdata  output  WIDTH  RAM write data.
- ram_we  output  1  RAM write enable.
- ram_raddr  output  ADDR_BITS  RAM read address.
- ram_rdata  input  WIDTH  RAM registered read data.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All state is cleared immediately on rst rising.
  - Cleared state: wr_ptr, rd_ptr, ram_words, rd_pending, out_count (0..2) and both buffer entries.
  - Outputs under reset: pop_valid=0, level=0, ram_we=0, ram_raddr=0, pop_data=0.
  - push_ready is 0 while rst is asserted.
- Push:
  - push_ready = (ram_words != DEPTH), taken from registered state only.
  - push_fire = push_valid & push_ready.
  - Combinationally: ram_we=push_fire, ram_waddr=wr_ptr, ram_wdata=push_data.
  - On push_fire, wr_ptr increments with natural wrap mod DEPTH.
- Read issue:
  - rd_issue = (ram_words != 0) & ((out_count + rd_pending - pop_fire) < 2).
  - ram_raddr = rd_ptr at all times.
  - On rd_issue, rd_ptr increments (wraps) and rd_pending is set for the next cycle.
- Capture: in a cycle with rd_pending=1, ram_rdata is written into the output buffer tail at the clock edge.
- ram_words next value = ram_words + push_fire - rd_issue.
  - Push and issue in the same cycle leave it unchanged.
- Hazard freedom:
  - A read is issued only when ram_words>0, so rd_ptr != wr_ptr except when full.
  - When full, push_ready=0, so a same-address read/write never occurs.
- Output buffer:
  - 2-entry FIFO of registers.
  - pop_valid = (out_count != 0); pop_data = head entry.
  - pop_fire = pop_valid & pop_ready.
  - Capture and pop in the same cycle are allowed; out_count never exceeds 2, guaranteed by the issue rule.
- Latency: push accepted in cycle t into an empty FIFO gives pop_valid=1 in cycle t+3.
- Throughput: steady state sustains 1 push + 1 pop per cycle with no bubbles.
- Capacity and level:
  - Total capacity is DEPTH+2.
  - level = ram_words + out_count + rd_pending, registered-state sum.
- Ignored inputs: pop_ready while pop_valid=0, and push_valid while push_ready=0, have no effect.
- Reset mid-operation: all contents are discarded. The first push after reset lands at RAM address 0.

Optional Feature:
- FIFO_CTRL_ERROR_EN: adds outputs err_overflow (1) and err_underflow (1), and input err_clear (1).
  - err_overflow is sticky; it sets on push_valid & !push_ready while not in reset.
  - err_underflow is sticky; it sets on pop_ready & !pop_valid.
  - Both flags clear on err_clear (set wins if both happen in the same cycle) and on rst.
- Without the macro: these ports and their logic do not exist.

Test Plan:
- Reset: assert rst mid-cycle with no clk edge -> pop_valid=0, level=0, ram_we=0 immediately; push_ready=1 after release.
- Latency: push 0xA5 at cycle t into an empty FIFO -> pop_valid rises at t+3 with pop_data=0xA5; level=1 from t+1.
- Fill, DEPTH=16, pop_ready=0: push 0..19 -> 18 words accepted; push_ready drops when level=18; ram_we never asserts while full.
- Streaming: 64 back-to-back pushes and pops (incrementing data) with a 2-cycle head start -> output in order, no bubbles after fill, pointers wrap 4 times.
- Backpressure: random pop_ready 50% with continuous push -> no loss or duplication; same-address read/write never occurs (assertion).
- FIFO_CTRL_ERROR_EN: push_valid while full -> err_overflow=1 held until err_clear; pop_ready on empty -> err_underflow=1.
